// File: rtl/pong_pkg.sv
// Shared encodings for the pong game-flow sequencer and the text overlay.
package pong_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_NEWBALL = 2'd1,
        ST_PLAY    = 2'd2,
        ST_OVER    = 2'd3
    } game_state_e;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Event inputs and game-status outputs of the pong game-flow sequencer.
interface pong_game_ctrl_if;

    logic                         refr_tick;
    logic                         start;
    logic                         hit;
    logic                         miss;
    pong_pkg::game_state_e        state;
    logic                         ball_en;
    logic                         ball_rst;
    logic                         game_over;
    logic [pong_pkg::BCD_W-1:0]   score_hi;
    logic [pong_pkg::BCD_W-1:0]   score_lo;
    logic [1:0]                   lives;

    // Master drives the events and observes the game status.
    modport master (
        output refr_tick, start, hit, miss,
        input  state, ball_en, ball_rst, game_over, score_hi, score_lo, lives
    );

    // Slave is the sequencer itself.
    modport slave (
        input  refr_tick, start, hit, miss,
        output state, ball_en, ball_rst, game_over, score_hi, score_lo, lives
    );

endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD incrementer: synchronous clear, increment enable, 99 wraps to 00.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] hi,
    output logic [BCD_W-1:0] lo
);

    logic [BCD_W-1:0] hi_q;
    logic [BCD_W-1:0] lo_q;

    // Digit registers; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (clr) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (inc) begin
            if (lo_q == BCD_W'(9)) begin
                lo_q <= '0;
                hi_q <= (hi_q == BCD_W'(9)) ? '0 : hi_q + BCD_W'(1);
            end else begin
                lo_q <= lo_q + BCD_W'(1);
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: new game, serve delay, play, game over.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned OVER_FRAMES  = 180,
    parameter int unsigned TW           = 8
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);

    localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_FRAMES - 1);
    localparam logic [TW-1:0] OVER_LOAD  = TW'(OVER_FRAMES - 1);
    localparam logic [1:0]    LIVES_LOAD = 2'(LIVES);

    game_state_e   state_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    lives_q;
    logic          start_q;

    logic start_rise;
    logic score_clr;
    logic score_inc;

    assign start_rise = bus.start & ~start_q;
    assign score_clr  = (state_q == ST_NEWGAME) & start_rise;
    // Miss has priority over a coincident hit.
    assign score_inc  = (state_q == ST_PLAY) & bus.hit & ~bus.miss;

    // Game FSM with frame timer, lives counter and start edge register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_NEWGAME;
            timer_q <= '0;
            lives_q <= LIVES_LOAD;
            // Reset high so a button held through reset release is not a press.
            start_q <= 1'b1;
        end else begin
            start_q <= bus.start;
            unique case (state_q)
                ST_NEWGAME: begin
                    if (start_rise) begin
                        state_q <= ST_NEWBALL;
                        timer_q <= SERVE_LOAD;
                        lives_q <= LIVES_LOAD;
                    end
                end
                ST_NEWBALL: begin
                    if (bus.refr_tick) begin
                        if (timer_q == '0) begin
                            state_q <= ST_PLAY;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.miss) begin
                        lives_q <= lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_q <= ST_OVER;
                            timer_q <= OVER_LOAD;
                        end else begin
                            state_q <= ST_NEWBALL;
                            timer_q <= SERVE_LOAD;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.refr_tick) begin
                        if (timer_q == '0) begin
                            state_q <= ST_NEWGAME;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                end
                default: state_q <= ST_NEWGAME;
            endcase
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .hi    (bus.score_hi),
        .lo    (bus.score_lo)
    );

    // Outputs decode the registered state only.
    assign bus.state     = state_q;
    assign bus.ball_en   = (state_q == ST_PLAY);
    assign bus.ball_rst  = (state_q != ST_PLAY);
    assign bus.game_over = (state_q == ST_OVER);
    assign bus.lives     = lives_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed-vector bench for pong_game_ctrl (LIVES=3, SERVE_FRAMES=4, OVER_FRAMES=3).
module tb_pong_game_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .LIVES        (3),
        .SERVE_FRAMES (4),
        .OVER_FRAMES  (3),
        .TW           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one cycle of events, then return 1 ns after the capturing edge.
    task automatic drive(input logic t, input logic s, input logic h, input logic m);
        bus.refr_tick = t;
        bus.start     = s;
        bus.hit       = h;
        bus.miss      = m;
        @(posedge clk);
        #1;
        bus.refr_tick = 1'b0;
        bus.start     = 1'b0;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic chk_score(input string tag, input logic [3:0] hi, input logic [3:0] lo);
        chk({tag, "_hi"}, 32'(bus.score_hi), 32'(hi));
        chk({tag, "_lo"}, 32'(bus.score_lo), 32'(lo));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.refr_tick = 1'b0;
        bus.start     = 1'b0;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        #23;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_ball_en", 32'(bus.ball_en), 32'd0);
        chk("rst_ball_rst", 32'(bus.ball_rst), 32'd1);
        chk("rst_game_over", 32'(bus.game_over), 32'd0);
        chk("rst_lives", 32'(bus.lives), 32'd3);
        chk_score("rst_score", 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1. Start then serve delay of four frames.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_newball", 32'(bus.state), 32'd1);
        ticks(3);
        chk("t1_tick3", 32'(bus.state), 32'd1);
        chk("t1_tick3_ball_en", 32'(bus.ball_en), 32'd0);
        ticks(1);
        chk("t1_play", 32'(bus.state), 32'd2);
        chk("t1_ball_en", 32'(bus.ball_en), 32'd1);
        chk("t1_ball_rst", 32'(bus.ball_rst), 32'd0);
        ticks(1);
        chk("t1_tick_in_play", 32'(bus.state), 32'd2);

        // 2. Scoring and 99 -> 00 wrap; tick coincident with hit.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2_tick_hit_state", 32'(bus.state), 32'd2);
        hits(11);
        chk_score("t2_12", 4'd1, 4'd2);
        hits(87);
        chk_score("t2_99", 4'd9, 4'd9);
        hits(1);
        chk_score("t2_wrap", 4'd0, 4'd0);

        // 3. Miss beats a coincident hit.
        hits(5);
        chk_score("t3_pre", 4'd0, 4'd5);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_lives", 32'(bus.lives), 32'd2);
        chk_score("t3_score", 4'd0, 4'd5);
        chk("t3_state", 32'(bus.state), 32'd1);
        chk("t3_ball_rst", 32'(bus.ball_rst), 32'd1);
        hits(1);
        chk_score("t3_hit_newball", 4'd0, 4'd5);

        // 4. Remaining misses end the game; start ignored in OVER.
        ticks(4);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_lives1", 32'(bus.lives), 32'd1);
        ticks(4);
        chk("t4_play_again", 32'(bus.state), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_over", 32'(bus.state), 32'd3);
        chk("t4_game_over", 32'(bus.game_over), 32'd1);
        chk("t4_lives0", 32'(bus.lives), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_start_ignored", 32'(bus.state), 32'd3);
        ticks(2);
        chk("t4_over_tick2", 32'(bus.state), 32'd3);
        ticks(1);
        chk("t4_newgame", 32'(bus.state), 32'd0);
        chk("t4_game_over_clr", 32'(bus.game_over), 32'd0);
        chk_score("t4_held", 4'd0, 4'd5);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_restart", 32'(bus.state), 32'd1);
        chk_score("t4_cleared", 4'd0, 4'd0);
        chk("t4_lives_reload", 32'(bus.lives), 32'd3);

        // 5. Start held through reset release is not a press.
        reset = 1'b0;
        bus.start = 1'b1;
        #20;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_held", 32'(bus.state), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_press", 32'(bus.state), 32'd1);

        // 6. Asynchronous reset mid-PLAY.
        ticks(4);
        hits(3);
        chk_score("t6_pre", 4'd0, 4'd3);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_async_state", 32'(bus.state), 32'd0);
        chk("t6_async_ball_en", 32'(bus.ball_en), 32'd0);
        chk("t6_async_ball_rst", 32'(bus.ball_rst), 32'd1);
        chk_score("t6_async_score", 4'd0, 4'd0);
        chk("t6_async_lives", 32'(bus.lives), 32'd3);
        @(posedge clk);
        #1;
        hits(2);
        chk_score("t6_hit_in_reset", 4'd0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_after", 32'(bus.state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
